// File: rtl/custom_instr_accum_pkg.sv
// Shared types and helpers for the custom_0 accumulator unit.
// Holds the custom_0 opcode value, the minor opcode enum, index types and
// the signed saturating add used when CUSTOM_INSTR_ACCUM_SATURATE_EN is defined.
package custom_instr_accum_pkg;

  localparam logic [4:0] CUSTOM_0 = 5'b00010;

  typedef enum logic [2:0] {
    MINOR_LOAD     = 3'd0,
    MINOR_ADD      = 3'd1,
    MINOR_READ     = 3'd2,
    MINOR_SUB      = 3'd3,
    MINOR_MAC      = 3'd4,
    MINOR_CLEAR    = 3'd5,
    MINOR_READCLR  = 3'd6,
    MINOR_RESERVED = 3'd7
  } minor_op_e;

  // Wide enough to hold any practical hart or accumulator index; used for
  // range checks against the configured counts.
  localparam int unsigned IDX_W = 16;
  typedef logic [IDX_W-1:0] hid_t;
  typedef logic [IDX_W-1:0] sel_t;

  typedef struct packed {
    logic               sat;
    logic signed [127:0] val;
  } sat_res_t;

  // Signed add clamped to a w-bit two's-complement range (w <= 63).
  function automatic sat_res_t sat_add(input logic signed [127:0] a,
                                       input logic signed [127:0] b,
                                       input int unsigned         w);
    logic signed [127:0] sum;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    sat_res_t            r;
    sum   = a + b;
    max_v = $signed((128'd1 << (w - 1)) - 128'd1);
    min_v = -max_v - 128'sd1;
    r.sat = 1'b0;
    r.val = sum;
    if (sum > max_v) begin
      r.sat = 1'b1;
      r.val = max_v;
    end else if (sum < min_v) begin
      r.sat = 1'b1;
      r.val = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/custom_instr_accum_pipe.sv
// Fixed-latency delay line carrying {valid, data} for instruction results.
// Latency: exactly LATENCY cycles from vld_i/dat_i to vld_o/dat_o.
// Backpressure: none; shifts every cycle, reset clears all stages at once.
module custom_instr_accum_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic [LATENCY-1:0]            vld_q;
  logic [LATENCY-1:0][WIDTH-1:0] dat_q;

  // Shift register: stage 0 captures the input, later stages follow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      dat_q[0] <= dat_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LATENCY-1];
  assign dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/custom_instr_accum_unit.sv
// Per-hart accumulator responder for custom_0 instructions (8 minor opcodes).
// Latency: RESULT_LATENCY (1..4) cycles from accept to result_out; one instr/cycle.
// Backpressure: none, never stalls. Optional CUSTOM_INSTR_ACCUM_SATURATE_EN = signed clamp.
module custom_instr_accum_unit
  import custom_instr_accum_pkg::*;
#(
  parameter int unsigned       HART_COUNT     = 2,
  parameter int unsigned       ACC_COUNT      = 4,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       RESULT_LATENCY = 1,
  parameter logic [DATA_W-1:0] DEFAULT_RESULT = 32'hdeadbeef,
  localparam int unsigned      HID_W = (HART_COUNT > 1) ? $clog2(HART_COUNT) : 1,
  localparam int unsigned      SEL_W = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [HID_W-1:0]  hid_in,
  input  logic [4:0]        major_opcode_in,
  input  logic [2:0]        minor_opcode_in,
  input  logic [DATA_W-1:0] op1_in,
  input  logic [DATA_W-1:0] op2_in,
  input  logic [31:0]       imm_in,
  input  logic [6:0]        funct7_in,
  output logic [DATA_W-1:0] result_out,
  output logic [15:0]       illegal_count_out
);

  logic [DATA_W-1:0] acc_q [HART_COUNT][ACC_COUNT];
  logic [15:0]       illegal_cnt_q, illegal_cnt_d;

  minor_op_e         minor;
  logic [SEL_W-1:0]  sel;
  logic              hid_ok, sel_ok, accept, illegal;
  logic [DATA_W-1:0] acc_old, acc_new;
  logic              wr_en, clr_all, rd_en;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_dat;
  logic              unused_imm;

  assign minor      = minor_op_e'(minor_opcode_in);
  assign sel        = imm_in[SEL_W-1:0];
  assign unused_imm = ^imm_in;
  assign hid_ok     = hid_t'(hid_in) < hid_t'(HART_COUNT);
  assign sel_ok     = sel_t'(sel) < sel_t'(ACC_COUNT);
  assign accept     = valid_in && (major_opcode_in == CUSTOM_0) && hid_ok;
  assign illegal    = (minor == MINOR_RESERVED) || (funct7_in != 7'd0);
  // Reads see state as of the accept edge: this is the pre-write value.
  assign acc_old    = sel_ok ? acc_q[hid_in][sel] : '0;

`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
  logic [HART_COUNT-1:0][ACC_COUNT-1:0] acc_sat_q;
  logic signed [127:0]         old_ext, op2_ext, prod_ext;
  logic signed [2*DATA_W-1:0]  prod_s;
  sat_res_t                    add_r, sub_r, mac_r;
  logic                        sat_hit, sat_clr;
  logic                        unused_sat;

  assign old_ext  = {{(128-DATA_W){acc_old[DATA_W-1]}}, acc_old};
  assign op2_ext  = {{(128-DATA_W){op2_in[DATA_W-1]}}, op2_in};
  assign prod_s   = $signed({{DATA_W{op1_in[DATA_W-1]}}, op1_in}) *
                    $signed({{DATA_W{op2_in[DATA_W-1]}}, op2_in});
  assign prod_ext = {{(128-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
  assign add_r    = sat_add(old_ext, op2_ext, DATA_W);
  assign sub_r    = sat_add(old_ext, -op2_ext, DATA_W);
  assign mac_r    = sat_add(old_ext, prod_ext, DATA_W);
  assign unused_sat = ^{add_r.val[127:DATA_W], sub_r.val[127:DATA_W], mac_r.val[127:DATA_W]};
`else
  logic [DATA_W-1:0] prod_lo;
  assign prod_lo = op1_in * op2_in;
`endif

  // Decode the accepted instruction into write/clear/read actions.
  always_comb begin
    acc_new = acc_old;
    wr_en   = 1'b0;
    clr_all = 1'b0;
    rd_en   = 1'b0;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
    sat_hit = 1'b0;
    sat_clr = 1'b0;
`endif
    if (accept && !illegal && sel_ok) begin
      unique case (minor)
        MINOR_LOAD: begin
          wr_en   = 1'b1;
          acc_new = op1_in;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
          sat_clr = 1'b1;
`endif
        end
        MINOR_ADD: begin
          wr_en = 1'b1;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
          acc_new = add_r.val[DATA_W-1:0];
          sat_hit = add_r.sat;
`else
          acc_new = acc_old + op2_in;
`endif
        end
        MINOR_SUB: begin
          wr_en = 1'b1;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
          acc_new = sub_r.val[DATA_W-1:0];
          sat_hit = sub_r.sat;
`else
          acc_new = acc_old - op2_in;
`endif
        end
        MINOR_MAC: begin
          wr_en = 1'b1;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
          acc_new = mac_r.val[DATA_W-1:0];
          sat_hit = mac_r.sat;
`else
          acc_new = acc_old + prod_lo;
`endif
        end
        MINOR_READ: rd_en = 1'b1;
        MINOR_CLEAR: begin
          clr_all = 1'b1;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
          sat_clr = 1'b1;
`endif
        end
        MINOR_READCLR: begin
          rd_en   = 1'b1;
          wr_en   = 1'b1;
          acc_new = '0;
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
          sat_clr = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Accumulator array: CLEAR wipes the whole hart, otherwise one entry is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int h = 0; h < int'(HART_COUNT); h++)
        for (int a = 0; a < int'(ACC_COUNT); a++)
          acc_q[h][a] <= '0;
    end else if (clr_all) begin
      for (int a = 0; a < int'(ACC_COUNT); a++)
        acc_q[hid_in][a] <= '0;
    end else if (wr_en) begin
      acc_q[hid_in][sel] <= acc_new;
    end
  end

`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
  // Sticky clamp flags, cleared by LOAD/READCLR (one entry) or CLEAR (whole hart).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_sat_q <= '0;
    end else if (clr_all) begin
      acc_sat_q[hid_in] <= '0;
    end else if (sat_clr) begin
      acc_sat_q[hid_in][sel] <= 1'b0;
    end else if (sat_hit) begin
      acc_sat_q[hid_in][sel] <= 1'b1;
    end
  end
`endif

  // Illegal-instruction counter, sticks at all-ones.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (accept && illegal && (illegal_cnt_q != 16'hffff))
      illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_cnt_q <= '0;
    else      illegal_cnt_q <= illegal_cnt_d;
  end

  custom_instr_accum_pipe #(
    .LATENCY (RESULT_LATENCY),
    .WIDTH   (DATA_W)
  ) u_pipe (
    .clk_i  (clk),
    .rst_ni (rst),
    .vld_i  (rd_en),
    .dat_i  (acc_old),
    .vld_o  (pipe_vld),
    .dat_o  (pipe_dat)
  );

  assign result_out        = pipe_vld ? pipe_dat : DEFAULT_RESULT;
  assign illegal_count_out = illegal_cnt_q;

endmodule

// File: tb/tb_custom_instr_accum_unit.sv
// Randomized + directed bench for custom_instr_accum_unit against a queue-based model.
// Model: per-hart accumulator arrays and a FIFO of expected results, LAT deep.
// Every cycle compares result_out and illegal_count_out at the falling edge.
module tb_custom_instr_accum_unit;
  import custom_instr_accum_pkg::*;

  localparam int          HC  = 2;
  localparam int          AC  = 4;
  localparam int          LAT = 3;
  localparam logic [31:0] DEF = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [0:0]  hid_in = '0;
  logic [4:0]  major_opcode_in = '0;
  logic [2:0]  minor_opcode_in = '0;
  logic [31:0] op1_in = '0, op2_in = '0, imm_in = '0;
  logic [6:0]  funct7_in = '0;
  logic [31:0] result_out;
  logic [15:0] illegal_count_out;

  always #5 clk = ~clk;

  custom_instr_accum_unit #(
    .HART_COUNT(HC), .ACC_COUNT(AC), .DATA_W(32),
    .RESULT_LATENCY(LAT), .DEFAULT_RESULT(DEF)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hid_in(hid_in),
    .major_opcode_in(major_opcode_in), .minor_opcode_in(minor_opcode_in),
    .op1_in(op1_in), .op2_in(op2_in), .imm_in(imm_in), .funct7_in(funct7_in),
    .result_out(result_out), .illegal_count_out(illegal_count_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] m_acc [HC][AC];
  int          m_cnt;
  logic [32:0] m_pipe [$];   // {valid, data}, front = result due this cycle

  task automatic model_reset();
    for (int h = 0; h < HC; h++)
      for (int a = 0; a < AC; a++) m_acc[h][a] = '0;
    m_cnt = 0;
    m_pipe.delete();
    for (int i = 0; i < LAT; i++) m_pipe.push_back(33'd0);
  endtask

  function automatic logic [31:0] clamp(input longint x);
    if (x > 64'sd2147483647)  return 32'h7fffffff;
    if (x < -64'sd2147483648) return 32'h80000000;
    return x[31:0];
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] acc, input logic [31:0] b);
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
    return clamp(longint'(signed'(acc)) + longint'(signed'(b)));
`else
    return acc + b;
`endif
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] acc, input logic [31:0] b);
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
    return clamp(longint'(signed'(acc)) - longint'(signed'(b)));
`else
    return acc - b;
`endif
  endfunction

  function automatic logic [31:0] m_mac(input logic [31:0] acc, input logic [31:0] a,
                                        input logic [31:0] b);
`ifdef CUSTOM_INSTR_ACCUM_SATURATE_EN
    return clamp(longint'(signed'(acc)) + longint'(signed'(a)) * longint'(signed'(b)));
`else
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return acc + p[31:0];
`endif
  endfunction

  // One cycle: check outputs due now, then drive and model the next instruction.
  task automatic step(input string tag, input logic v, input int h, input logic [4:0] maj,
                      input int mn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input int f7);
    logic [32:0] e;
    logic [31:0] old;
    int          s;
    @(negedge clk);
    e = m_pipe.pop_front();
    check({tag, " result"}, result_out, e[32] ? e[31:0] : DEF);
    check({tag, " count"}, 32'(illegal_count_out), 32'(m_cnt));
    valid_in = v; hid_in = 1'(h); major_opcode_in = maj; minor_opcode_in = 3'(mn);
    op1_in = a; op2_in = b; imm_in = imm; funct7_in = 7'(f7);
    e = 33'd0;
    if (v && maj == CUSTOM_0 && h < HC) begin
      if (mn == 7 || f7 != 0) begin
        if (m_cnt < 65535) m_cnt++;
      end else begin
        s   = int'(imm[1:0]);
        old = m_acc[h][s];
        case (mn)
          0: m_acc[h][s] = a;
          1: m_acc[h][s] = m_add(old, b);
          2: e = {1'b1, old};
          3: m_acc[h][s] = m_sub(old, b);
          4: m_acc[h][s] = m_mac(old, a, b);
          5: for (int i = 0; i < AC; i++) m_acc[h][i] = '0;
          6: begin e = {1'b1, old}; m_acc[h][s] = '0; end
          default: ;
        endcase
      end
    end
    m_pipe.push_back(e);
  endtask

  task automatic op(input string tag, input int h, input int mn, input logic [31:0] a,
                    input logic [31:0] b, input int sel);
    step(tag, 1'b1, h, CUSTOM_0, mn, a, b, 32'(sel), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset while results are in flight.
  task automatic mid_reset();
    logic [32:0] e;
    @(posedge clk);
    #2;
    e = m_pipe[0];
    check("pre-reset result", result_out, e[32] ? e[31:0] : DEF);
    rst = 1'b0;
    valid_in = 1'b0;
    #1;
    check("reset result", result_out, DEF);
    check("reset count", 32'(illegal_count_out), 32'd0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b, imm;
    logic [4:0]  maj;
    int          f7;
    model_reset();
    #12;
    check("por result", result_out, DEF);
    check("por count", 32'(illegal_count_out), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    // LOAD/ADD/READ -> 12
    op("load5", 0, 0, 5, 0, 0);
    op("add7", 0, 1, 0, 7, 0);
    op("read12", 0, 2, 0, 0, 0);
    idle(LAT + 1);
    // Hart isolation
    op("h1 load100", 1, 0, 100, 0, 2);
    op("h0 load1", 0, 0, 1, 0, 2);
    op("h1 read", 1, 2, 0, 0, 2);
    op("h0 read", 0, 2, 0, 0, 2);
    // MAC then READCLR/READ -> 23, 0
    op("load3", 0, 0, 3, 0, 1);
    op("mac", 0, 4, 4, 5, 1);
    op("readclr", 0, 6, 0, 0, 1);
    op("read0", 0, 2, 0, 0, 1);
    // Back-to-back reads of 1,2,3
    op("l1", 1, 0, 1, 0, 0);
    op("l2", 1, 0, 2, 0, 1);
    op("l3", 1, 0, 3, 0, 3);
    op("r1", 1, 2, 0, 0, 0);
    op("r2", 1, 2, 0, 0, 1);
    op("r3", 1, 2, 0, 0, 3);
    idle(LAT);
    // Illegal: minor 7, then ADD with funct7=1; accumulator must stay 12
    op("minor7", 0, 7, 0, 9, 0);
    step("funct7", 1'b1, 0, CUSTOM_0, 1, 0, 9, 0, 1);
    op("read after illegal", 0, 2, 0, 0, 0);
    // Non-custom_0 major opcode does nothing
    step("other major", 1'b1, 0, 5'b01011, 0, 32'h55, 0, 0, 0);
    op("read after other", 0, 2, 0, 0, 0);
    // Signed overflow boundary (wrap or clamp depending on build)
    op("load big", 0, 0, 32'h7ffffff0, 0, 3);
    op("add 0x20", 0, 1, 0, 32'h20, 3);
    op("read big", 0, 2, 0, 0, 3);
    op("sub wrap", 0, 3, 0, 32'hffffffff, 3);
    op("read sub", 0, 2, 0, 0, 3);
    // CLEAR hart 1 only
    op("clear h1", 1, 5, 0, 0, 0);
    op("read h1", 1, 2, 0, 0, 3);
    op("read h0", 0, 2, 0, 0, 2);
    // Reset with reads in flight
    op("pr l", 1, 0, 32'h1234, 0, 1);
    op("pr r1", 1, 2, 0, 0, 1);
    op("pr r2", 1, 2, 0, 0, 1);
    op("pr r3", 1, 2, 0, 0, 1);
    mid_reset();
    idle(LAT + 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      a   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
      b   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
      imm = {$urandom_range(0, 3) == 0 ? 30'($urandom) : 30'd0, 2'($urandom_range(0, 3))};
      maj = ($urandom_range(0, 9) == 0) ? 5'($urandom) : CUSTOM_0;
      f7  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 127) : 0;
      step("rand", $urandom_range(0, 7) != 0, $urandom_range(0, HC - 1), maj,
           $urandom_range(0, 7), a, b, imm, f7);
    end

    // Drive the illegal counter into saturation
    for (int i = 0; i < 65540; i++) op("sat cnt", $urandom_range(0, 1), 7, 0, 0, 0);
    op("post sat", 0, 2, 0, 0, 0);
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
